// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// Default payload widths match a 512 x 32 RAM instance.
package ram_arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned CMD_DATA_W = 32;
    localparam int unsigned CMD_DEEP   = 512;
    localparam int unsigned CMD_ADDR_W = $clog2(CMD_DEEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  id;
    } cmd_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way arbiter with registered round-robin pointer.
// RAM_ARB_FIXED_PRIO_EN selects fixed priority (master 0 first) and drops the pointer flop.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    assign ptr = 1'b0;

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst_n, advance};
`else
    logic ptr_q;
    logic ptr_d;

    // Pointer names the preferred master; after a grant it moves to the loser.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (advance) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two masters onto one single-port RAM and sequences its strobes and data bus.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDE = CMD_DATA_W,
    parameter int unsigned DEEP      = CMD_DEEP,
    parameter int unsigned ADDR_WIDE = $clog2(DEEP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_i,
    input  logic [1:0]           we_i,
    input  logic [ADDR_WIDE-1:0] addr_i  [NUM_REQ],
    input  logic [DATA_WIDE-1:0] wdata_i [NUM_REQ],
    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [DATA_WIDE-1:0] rdata_o,
    output logic                 busy_o,
    output logic                 ram_wr_en,
    output logic                 ram_re_en,
    output logic [ADDR_WIDE-1:0] ram_addr,
    inout  wire  [DATA_WIDE-1:0] ram_data_io
);

    state_t               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic [1:0]           rvalid_q, rvalid_d;
    logic [DATA_WIDE-1:0] rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 wr_en_q, wr_en_d;
    logic                 re_en_q, re_en_d;
    logic [1:0]           arb_gnt;
    logic                 arb_adv;
    logic                 win_c;
    logic                 ptr_unused;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_i),
        .advance (arb_adv),
        .gnt     (arb_gnt),
        .ptr     (ptr_unused)
    );

    // Next-state, command latch and strobe decode; strobes are registered into ISSUE.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        wr_en_d  = 1'b0;
        re_en_d  = 1'b0;
        gnt_o    = 2'b00;
        arb_adv  = 1'b0;
        win_c    = arb_gnt[1];

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    gnt_o       = arb_gnt;
                    arb_adv     = 1'b1;
                    cmd_d.we    = we_i[win_c];
                    cmd_d.addr  = CMD_ADDR_W'(addr_i[win_c]);
                    cmd_d.wdata = CMD_DATA_W'(wdata_i[win_c]);
                    cmd_d.id    = win_c;
                    wr_en_d     = we_i[win_c];
                    re_en_d     = ~we_i[win_c];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = cmd_q.we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // RAM drives the bus now; sample at the end of WAIT so data is visible in CAPTURE.
                rdata_d            = ram_data_io;
                rvalid_d[cmd_q.id] = 1'b1;
                state_d            = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            re_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            wr_en_q  <= wr_en_d;
            re_en_q  <= re_en_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign ram_wr_en   = wr_en_q;
    assign ram_re_en   = re_en_q;
    assign ram_addr    = ADDR_WIDE'(cmd_q.addr);
    assign ram_data_io = wr_en_q ? DATA_WIDE'(cmd_q.wdata) : {DATA_WIDE{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-timeline model, behavioural RAM, directed and random traffic.
module tb_ram_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    gnt_o, rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          busy_o, ram_wr_en, ram_re_en;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data_io;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDE(DW), .DEEP(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .ram_wr_en   (ram_wr_en),
        .ram_re_en   (ram_re_en),
        .ram_addr    (ram_addr),
        .ram_data_io (ram_data_io)
    );

    function automatic logic [DW-1:0] init_word(input int k);
        return 32'(k) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Behavioural RAM: registered read, drives the bus in the cycle after re_en.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_q      = '0;
    logic          ram_oe     = 1'b0;
    logic          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int k = 0; k < DEPTH; k++) ram_mem[k] <= init_word(k);
            ram_loaded <= 1'b1;
        end
        if (ram_wr_en) ram_mem[ram_addr] <= ram_data_io;
        ram_oe <= ram_re_en;
        if (ram_re_en) ram_q <= ram_mem[ram_addr];
    end
    assign ram_data_io = ram_oe ? ram_q : {DW{1'bz}};

    // Reference model: cycles elapsed since the current grant, plus a shadow memory.
    logic [DW-1:0] sb_mem [DEPTH];
    int            m_phase;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_id;
    int            m_ptr;
    logic [DW-1:0] m_rdata;
    logic [1:0]    gnt_evt;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit rand_mode  = 1'b0;
    int auto_cnt [2];

    logic [1:0]    gnt_log [$];
    int            gnt_cyc [$];
    logic [1:0]    rv_id   [$];
    logic [DW-1:0] rv_dat  [$];
    int            rv_cyc  [$];
    logic [AW-1:0] addr_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] gl(input int k);
        return (k < gnt_log.size()) ? gnt_log[k] : 2'b00;
    endfunction
    function automatic logic [1:0] rvi(input int k);
        return (k < rv_id.size()) ? rv_id[k] : 2'b00;
    endfunction
    function automatic logic [DW-1:0] rvd(input int k);
        return (k < rv_dat.size()) ? rv_dat[k] : '0;
    endfunction
    function automatic int rvc(input int k);
        return (k < rv_cyc.size()) ? rv_cyc[k] : -1;
    endfunction
    function automatic int gcy(input int k);
        return (k < gnt_cyc.size()) ? gnt_cyc[k] : -100;
    endfunction
    function automatic logic [AW-1:0] al(input int k);
        return (k < addr_log.size()) ? addr_log[k] : '0;
    endfunction

    // Compare DUT outputs against the model for this cycle, then advance the model.
    task automatic check_cycle();
        logic [1:0]    exp_gnt;
        logic [DW-1:0] exp_rd;
        int            win;
        cyc++;
        if (!rst_n) begin
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_wr_en", ram_wr_en, 0);
            chk("rst_re_en", ram_re_en, 0);
            chk("rst_addr", ram_addr, 0);
            m_phase = 0; m_ptr = 0; m_rdata = '0; gnt_evt = 2'b00;
            return;
        end
        exp_gnt = 2'b00;
        win     = 0;
        if (m_phase == 0 && req != 2'b00) begin
            if (req == 2'b11) win = FIXED ? 0 : m_ptr;
            else              win = req[1] ? 1 : 0;
            exp_gnt = 2'b01 << win;
        end
        exp_rd = (m_phase == 3) ? sb_mem[m_addr] : m_rdata;
        chk("gnt", gnt_o, exp_gnt);
        chk("busy", busy_o, (m_phase != 0));
        chk("wr_en", ram_wr_en, (m_phase == 1 && m_we));
        chk("re_en", ram_re_en, (m_phase == 1 && !m_we));
        chk("wr_re_excl", ram_wr_en & ram_re_en, 0);
        chk("rvalid", rvalid_o, (m_phase == 3) ? (2'b01 << m_id) : 2'b00);
        chk("rdata", rdata_o, exp_rd);
        if (m_phase == 1) chk("ram_addr", ram_addr, m_addr);
        if (m_phase == 1 && m_we) chk("wr_bus", ram_data_io, m_wdata);
        if (m_phase == 2) chk("wait_bus", ram_data_io, sb_mem[m_addr]);

        if (gnt_o != 2'b00) begin gnt_log.push_back(gnt_o); gnt_cyc.push_back(cyc); end
        if (rvalid_o != 2'b00) begin
            rv_id.push_back(rvalid_o); rv_dat.push_back(rdata_o); rv_cyc.push_back(cyc);
        end
        if (ram_wr_en | ram_re_en) addr_log.push_back(ram_addr);

        gnt_evt = exp_gnt;
        case (m_phase)
            0: if (exp_gnt != 2'b00) begin
                   m_we = we[win]; m_addr = addr[win]; m_wdata = wdata[win];
                   m_id = win; m_ptr = 1 - win; m_phase = 1;
               end
            1: if (m_we) begin sb_mem[m_addr] = m_wdata; m_phase = 0; end
               else m_phase = 2;
            2: m_phase = 3;
            default: begin m_rdata = sb_mem[m_addr]; m_phase = 0; end
        endcase
    endtask

    task automatic new_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    endtask

    task automatic rand_cmd(input int i);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
        new_cmd(i, 1'($urandom_range(0, 1)), a, $urandom());
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (gnt_evt[i]) begin
                if (auto_cnt[i] > 0) begin auto_cnt[i]--; rand_cmd(i); end
                else req[i] = 1'b0;
            end else if (rand_mode && req[i] && $urandom_range(0, 19) == 0) begin
                req[i] = 1'b0;
            end
            if (rand_mode && !req[i] && $urandom_range(0, 2) == 0) rand_cmd(i);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((req != 2'b00 || m_phase != 0 || auto_cnt[0] != 0 || auto_cnt[1] != 0) && n < budget) begin
            tick();
            n++;
        end
        if (req != 2'b00 || m_phase != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
    endtask

    int b, rb, ab, rv_before;

    initial begin
        for (int k = 0; k < DEPTH; k++) sb_mem[k] = init_word(k);
        m_phase = 0; m_ptr = 0; m_rdata = '0; gnt_evt = 2'b00;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_id = 0;
        auto_cnt[0] = 0; auto_cnt[1] = 0;
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Both masters read at once from reset: master 0 first.
        b = gnt_log.size(); rb = rv_id.size();
        new_cmd(0, 1'b0, 9'd10, 32'h1111_1111);
        new_cmd(1, 1'b0, 9'd20, 32'h2222_2222);
        wait_idle(40, "simul_reads");
        chk("simul_gnt0", gl(b), 2'b01);
        chk("simul_gnt1", gl(b + 1), 2'b10);
        chk("simul_rv0", rvi(rb), 2'b01);
        chk("simul_rd0", rvd(rb), init_word(10));
        chk("simul_rv1", rvi(rb + 1), 2'b10);
        chk("simul_rd1", rvd(rb + 1), init_word(20));

        // Master 0 write then read of address 132.
        b = gnt_log.size(); rb = rv_id.size();
        new_cmd(0, 1'b1, 9'd132, 32'h0000_09FB);
        wait_idle(20, "wr132");
        new_cmd(0, 1'b0, 9'd132, 32'h0);
        wait_idle(20, "rd132");
        chk("wr_rd_gnt0", gl(b), 2'b01);
        chk("wr_rd_gnt1", gl(b + 1), 2'b01);
        chk("wr_rd_rv", rvi(rb), 2'b01);
        chk("wr_rd_data", rvd(rb), 32'h0000_09FB);
        chk("wr_rd_latency", 64'(rvc(rb) - gcy(b + 1)), 64'd3);

        // Sustained contention: pointer currently favours master 1 (master 0 won last).
        b = gnt_log.size();
        auto_cnt[0] = 7; auto_cnt[1] = 7;
        rand_cmd(0); rand_cmd(1);
        wait_idle(120, "contention");
        for (int k = 0; k < 8; k++) begin
            if (FIXED) chk("contend_gnt", gl(b + k), 2'b01);
            else       chk("contend_gnt", gl(b + k), (k % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Top-of-range address write and read back.
        ab = addr_log.size(); rb = rv_id.size();
        new_cmd(1, 1'b1, 9'h1FF, 32'hDEAD_BEEF);
        wait_idle(20, "wr511");
        new_cmd(1, 1'b0, 9'h1FF, 32'h0);
        wait_idle(20, "rd511");
        chk("wrap_addr_wr", al(ab), 9'h1FF);
        chk("wrap_addr_rd", al(ab + 1), 9'h1FF);
        chk("wrap_rv", rvi(rb), 2'b10);
        chk("wrap_data", rvd(rb), 32'hDEAD_BEEF);

        // Reset asserted during the WAIT cycle of a read.
        new_cmd(0, 1'b0, 9'd133, 32'h0);
        begin
            int n = 0;
            while (m_phase != 2 && n < 20) begin tick(); n++; end
            if (m_phase != 2) begin
                vectors++; miscompares++;
                $display("FAIL rst_mid_read: WAIT never reached");
            end
        end
        rst_n = 1'b0;
        req = 2'b00;
        rv_before = rv_id.size();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_no_rvalid", 64'(rv_id.size() - rv_before), 64'd0);
        b = gnt_log.size();
        new_cmd(0, 1'b0, 9'd5, 32'h0);
        new_cmd(1, 1'b0, 9'd6, 32'h0);
        wait_idle(40, "post_rst");
        chk("rst_first_gnt", gl(b), 2'b01);

        // Random mixed traffic with request drops.
        rand_mode = 1'b1;
        repeat (800) tick();
        rand_mode = 1'b0;
        wait_idle(60, "drain");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
